// File: rtl/uart_wb_pkg.sv
// ---------------------------------------------------------------------------
// uart_wb_pkg
// Shared definitions for the Wishbone UART slave: register offsets within
// the UART window, STATUS bit positions, and the 2-bit TX/RX FSM encodings.
// ---------------------------------------------------------------------------
package uart_wb_pkg;

    // Register byte offsets (bits [1:0] of the bus address are ignored)
    localparam logic [3:0] UART_DATA = 4'h0;
    localparam logic [3:0] UART_STAT = 4'h4;
    localparam logic [3:0] UART_CTRL = 4'h8;

    // STATUS register bit indices
    localparam int STAT_RX_AVAIL   = 0;
    localparam int STAT_TX_FULL    = 1;
    localparam int STAT_RX_OVERRUN = 2;   // write 1 to clear
    localparam int STAT_TX_IDLE    = 3;
    localparam int STAT_FRAME_ERR  = 4;   // write 1 to clear

    // CTRL register bit indices
    localparam int CTRL_RX_IRQ_EN  = 0;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock first-word-fall-through FIFO used for both the TX and RX byte
// queues. dout always shows the oldest entry so a pop and its data are
// consumed in the same cycle.
//   clk, rst   : clock, asynchronous active-high reset (pointers only)
//   push, din  : write request / data; ignored while full
//   pop        : read request; ignored while empty
//   dout       : oldest entry (don't care while empty)
//   full, empty: occupancy flags
// ---------------------------------------------------------------------------
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2**AW];

    // One extra pointer bit distinguishes full from empty when the
    // address bits are equal.
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;

    logic do_push;
    logic do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr_reg[AW-1:0]];

    // Storage carries no reset; validity is defined by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_wb_slave.sv
// ---------------------------------------------------------------------------
// uart_wb_slave
// Wishbone slave UART, 8N1, fixed baud divider. CPU writes to DATA are
// queued and serialized on uart_txd; frames arriving on uart_rxd are queued
// for the CPU to poll. irq_o is a level interrupt for "RX data pending".
//   clk, rst          : system clock, asynchronous active-high reset
//   wb_cyc_i/stb_i    : bus request
//   wb_we_i           : 1 = write
//   wb_adr_i[3:2]     : register select (DATA/STATUS/CTRL/reserved)
//   wb_sel_i[0]       : byte-lane enable for DATA writes
//   wb_dat_i/dat_o    : write / read data
//   wb_ack_o          : single-cycle acknowledge
//   uart_txd/uart_rxd : serial line out / in (rxd asynchronous)
//   irq_o             : rx_irq_en & rx_avail, registered
// CLK_DIV (clocks per bit) must be at least 4.
// ---------------------------------------------------------------------------
module uart_wb_slave
    import uart_wb_pkg::*;
#(
    parameter int CLK_DIV = 434,
    parameter int FIFO_AW = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        uart_txd,
    input  logic        uart_rxd,
    output logic        irq_o
);

    localparam int              CW       = $clog2(CLK_DIV);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]   CNT_HALF = CW'(CLK_DIV / 2);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic        held_reg;      // acked request whose strobe is still up
    logic        bus_req;
    logic        bus_wr;
    logic        bus_rd;
    logic [3:0]  reg_adr;
    logic [31:0] rd_data;
    logic [31:0] status_vec;
    logic        ctrl_reg;
    logic        overrun_reg;
    logic        frame_err_reg;
    logic        irq_reg;
    logic        unused_bits;

    assign reg_adr = {wb_adr_i[3:2], 2'b00};
    assign bus_req = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~held_reg;
    assign bus_wr  = bus_req & wb_we_i;
    assign bus_rd  = bus_req & ~wb_we_i;

    assign unused_bits = ^{wb_adr_i[1:0], wb_sel_i[3:1], wb_dat_i[31:8]};

    // ------------------------------------------------------------------
    // FIFOs
    // ------------------------------------------------------------------
    logic       tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0] tx_dout;
    logic       rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0] rx_dout;
    logic [7:0] rx_shift_reg;

    assign tx_push = bus_wr & (reg_adr == UART_DATA) & wb_sel_i[0];
    assign rx_pop  = bus_rd & (reg_adr == UART_DATA);

    uart_sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (wb_dat_i[7:0]),
        .dout  (tx_dout),
        .full  (tx_full),
        .empty (tx_empty)
    );

    uart_sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (rx_shift_reg),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    tx_state_t   tx_state_reg;
    logic [CW-1:0] tx_cnt_reg;
    logic [7:0]  tx_shift_reg;
    logic [2:0]  tx_bit_reg;
    logic        txd_reg;

    // A byte is taken either from IDLE or at the end of a stop bit, the
    // latter chaining frames with no idle gap.
    assign tx_pop = ~tx_empty &
                    ((tx_state_reg == TX_IDLE) ||
                     ((tx_state_reg == TX_STOP) && (tx_cnt_reg == '0)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_reg <= TX_IDLE;
            tx_cnt_reg   <= '0;
            tx_shift_reg <= '0;
            tx_bit_reg   <= '0;
            txd_reg      <= 1'b1;
        end else begin
            case (tx_state_reg)
                TX_IDLE: begin
                    if (tx_pop) begin
                        tx_shift_reg <= tx_dout;
                        txd_reg      <= 1'b0;
                        tx_cnt_reg   <= CNT_MAX;
                        tx_state_reg <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt_reg == '0) begin
                        txd_reg      <= tx_shift_reg[0];
                        tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
                        tx_bit_reg   <= '0;
                        tx_cnt_reg   <= CNT_MAX;
                        tx_state_reg <= TX_DATA;
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg - CNT_ONE;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_reg == '0) begin
                        tx_cnt_reg <= CNT_MAX;
                        if (tx_bit_reg == 3'd7) begin
                            txd_reg      <= 1'b1;
                            tx_state_reg <= TX_STOP;
                        end else begin
                            txd_reg      <= tx_shift_reg[0];
                            tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
                            tx_bit_reg   <= tx_bit_reg + 3'd1;
                        end
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg - CNT_ONE;
                    end
                end
                default: begin // TX_STOP
                    if (tx_cnt_reg == '0) begin
                        if (tx_pop) begin
                            tx_shift_reg <= tx_dout;
                            txd_reg      <= 1'b0;
                            tx_cnt_reg   <= CNT_MAX;
                            tx_state_reg <= TX_START;
                        end else begin
                            tx_state_reg <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg - CNT_ONE;
                    end
                end
            endcase
        end
    end

    assign uart_txd = txd_reg;

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    logic [1:0]    rxd_sync_reg;
    logic          rxd_prev_reg;
    logic          rxd_s;
    logic          rxd_fall;
    rx_state_t     rx_state_reg;
    logic [CW-1:0] rx_cnt_reg;
    logic [2:0]    rx_bit_reg;
    logic          rx_stop_now;
    logic          overrun_set;
    logic          frame_set;

    assign rxd_s    = rxd_sync_reg[1];
    // Edge detection also provides the rearm rule after a framing error:
    // nothing starts until the line has been seen high again.
    assign rxd_fall = rxd_prev_reg & ~rxd_s;

    assign rx_stop_now = (rx_state_reg == RX_STOP) && (rx_cnt_reg == '0);
    assign rx_push     = rx_stop_now & rxd_s;
    assign overrun_set = rx_push & rx_full;
    assign frame_set   = rx_stop_now & ~rxd_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_sync_reg <= 2'b11;
            rxd_prev_reg <= 1'b1;
        end else begin
            rxd_sync_reg <= {rxd_sync_reg[0], uart_rxd};
            rxd_prev_reg <= rxd_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_reg <= RX_IDLE;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_shift_reg <= '0;
        end else begin
            case (rx_state_reg)
                RX_IDLE: begin
                    if (rxd_fall) begin
                        rx_cnt_reg   <= CNT_HALF;
                        rx_state_reg <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt_reg == '0) begin
                        if (rxd_s) begin
                            rx_state_reg <= RX_IDLE;   // glitch, not a start bit
                        end else begin
                            rx_bit_reg   <= '0;
                            rx_cnt_reg   <= CNT_MAX;
                            rx_state_reg <= RX_DATA;
                        end
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg - CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_reg == '0) begin
                        rx_shift_reg <= {rxd_s, rx_shift_reg[7:1]};
                        rx_cnt_reg   <= CNT_MAX;
                        if (rx_bit_reg == 3'd7) begin
                            rx_state_reg <= RX_STOP;
                        end else begin
                            rx_bit_reg <= rx_bit_reg + 3'd1;
                        end
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg - CNT_ONE;
                    end
                end
                default: begin // RX_STOP; push/flags are decoded from rx_stop_now
                    if (rx_cnt_reg == '0) begin
                        rx_state_reg <= RX_IDLE;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg - CNT_ONE;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers and bus response
    // ------------------------------------------------------------------
    always_comb begin
        status_vec                  = '0;
        status_vec[STAT_RX_AVAIL]   = ~rx_empty;
        status_vec[STAT_TX_FULL]    = tx_full;
        status_vec[STAT_RX_OVERRUN] = overrun_reg;
        status_vec[STAT_TX_IDLE]    = tx_empty & (tx_state_reg == TX_IDLE);
        status_vec[STAT_FRAME_ERR]  = frame_err_reg;
    end

    always_comb begin
        rd_data = '0;
        case (reg_adr)
            UART_DATA: rd_data = {24'b0, (rx_empty ? 8'h00 : rx_dout)};
            UART_STAT: rd_data = status_vec;
            UART_CTRL: rd_data = {31'b0, ctrl_reg};
            default:   rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_ack_o      <= 1'b0;
            wb_dat_o      <= '0;
            held_reg      <= 1'b0;
            ctrl_reg      <= 1'b0;
            overrun_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
            irq_reg       <= 1'b0;
        end else begin
            wb_ack_o <= bus_req;
            held_reg <= wb_cyc_i & wb_stb_i & (wb_ack_o | held_reg);
            if (bus_rd) begin
                wb_dat_o <= rd_data;
            end
            if (bus_wr && (reg_adr == UART_CTRL)) begin
                ctrl_reg <= wb_dat_i[CTRL_RX_IRQ_EN];
            end
            // A set event in the same cycle as a W1C clear wins.
            if (overrun_set) begin
                overrun_reg <= 1'b1;
            end else if (bus_wr && (reg_adr == UART_STAT) && wb_dat_i[STAT_RX_OVERRUN]) begin
                overrun_reg <= 1'b0;
            end
            if (frame_set) begin
                frame_err_reg <= 1'b1;
            end else if (bus_wr && (reg_adr == UART_STAT) && wb_dat_i[STAT_FRAME_ERR]) begin
                frame_err_reg <= 1'b0;
            end
            irq_reg <= ctrl_reg & ~rx_empty;
        end
    end

    assign irq_o = irq_reg;

endmodule

// File: tb/tb_uart_wb_slave.sv
// ---------------------------------------------------------------------------
// tb_uart_wb_slave
// Randomized bench for uart_wb_slave. A queue-based model tracks the RX
// FIFO contents, flags and expected TX byte stream; a serial monitor
// decodes uart_txd independently. A short bit time keeps the run small.
// ---------------------------------------------------------------------------
module tb_uart_wb_slave;
    import uart_wb_pkg::*;

    localparam int CLK_DIV = 20;
    localparam int FIFO_AW = 4;
    localparam int DEPTH   = 16;
    localparam int FRAME   = 10 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_cyc, wb_stb, wb_we;
    logic [3:0]  wb_adr, wb_sel;
    logic [31:0] wb_dat_w, wb_dat_r;
    logic        wb_ack;
    logic        uart_txd;
    logic        uart_rxd;
    logic        irq;

    always #5 clk = ~clk;

    uart_wb_slave #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .wb_cyc_i (wb_cyc),
        .wb_stb_i (wb_stb),
        .wb_we_i  (wb_we),
        .wb_adr_i (wb_adr),
        .wb_sel_i (wb_sel),
        .wb_dat_i (wb_dat_w),
        .wb_dat_o (wb_dat_r),
        .wb_ack_o (wb_ack),
        .uart_txd (uart_txd),
        .uart_rxd (uart_rxd),
        .irq_o    (irq)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_rx_q[$];
    logic [7:0] tx_exp[$];
    bit m_overrun, m_frame, m_tx_busy, m_tx_full;

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s = '0;
        s[STAT_RX_AVAIL]   = (m_rx_q.size() != 0);
        s[STAT_TX_FULL]    = m_tx_full;
        s[STAT_RX_OVERRUN] = m_overrun;
        s[STAT_TX_IDLE]    = !m_tx_busy;
        s[STAT_FRAME_ERR]  = m_frame;
        return s;
    endfunction

    // ---------------- TX monitor ----------------
    int         cyc = 0;
    bit         mon_en = 1'b1;
    logic [7:0] tx_got[$];
    int         tx_start_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        int t0;
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (mon_en && rst === 1'b0 && uart_txd === 1'b0) begin
                t0 = cyc;
                repeat (CLK_DIV / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CLK_DIV) @(negedge clk);
                    b[i] = uart_txd;
                end
                repeat (CLK_DIV) @(negedge clk);
                check("tx_stop_bit", uart_txd, 1);
                tx_got.push_back(b);
                tx_start_cyc.push_back(t0);
            end
        end
    end

    // ---------------- bus and serial drivers ----------------
    task automatic wb_xfer(input logic we, input logic [3:0] adr, input logic [31:0] wdat,
                           input logic [3:0] sel, output logic [31:0] rdat);
        int waited;
        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
        wb_adr = adr; wb_sel = sel; wb_dat_w = wdat;
        waited = 0;
        do begin
            @(posedge clk); #1;
            waited++;
        end while (!wb_ack && waited < 8);
        check("ack_latency", waited, 1);
        rdat = wb_dat_r;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        $display("wb %s adr=0x%0h dat=0x%08h", we ? "wr" : "rd", adr, we ? wdat : rdat);
    endtask

    task automatic wb_write(input logic [3:0] adr, input logic [31:0] wdat);
        logic [31:0] dummy;
        wb_xfer(1'b1, adr, wdat, 4'hF, dummy);
    endtask

    task automatic wb_read(input logic [3:0] adr, output logic [31:0] rdat);
        wb_xfer(1'b0, adr, 32'h0, 4'hF, rdat);
    endtask

    task automatic read_check(input string tag, input logic [3:0] adr, input logic [31:0] exp);
        logic [31:0] r;
        wb_read(adr, r);
        check(tag, r, exp);
    endtask

    // DATA read against the model: pops the model queue when non-empty.
    task automatic read_data_check(input string tag);
        logic [31:0] exp;
        exp = 32'h0;
        if (m_rx_q.size() != 0) exp = {24'h0, m_rx_q.pop_front()};
        read_check(tag, UART_DATA, exp);
    endtask

    // One 8N1 frame followed by one idle bit time.
    task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rxd = fr[i];
            repeat (CLK_DIV) @(posedge clk); #1;
        end
        uart_rxd = 1'b1;
        repeat (CLK_DIV) @(posedge clk); #1;
        if (!stop_bit) m_frame = 1'b1;
        else if (m_rx_q.size() < DEPTH) m_rx_q.push_back(b);
        else m_overrun = 1'b1;
        $display("rx frame 0x%02h stop=%0b", b, stop_bit);
    endtask

    task automatic wait_tx_idle(input int budget);
        logic [31:0] s;
        int t;
        t = 0;
        do begin
            repeat (100) @(posedge clk); #1;
            t += 100;
            wb_read(UART_STAT, s);
        end while (!s[STAT_TX_IDLE] && t < budget);
        check("tx_idle_wait", s[STAT_TX_IDLE], 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] r, w;
        logic [7:0]  b;
        logic [9:0]  fr;
        int acks, mism, slots, n;

        rst = 1'b1; wb_cyc = 0; wb_stb = 0; wb_we = 0;
        wb_adr = 0; wb_sel = 0; wb_dat_w = 0; uart_rxd = 1'b1;
        repeat (3) @(posedge clk); #1;
        check("rst_ack", wb_ack, 0);
        check("rst_dat", wb_dat_r, 0);
        check("rst_txd", uart_txd, 1);
        check("rst_irq", irq, 0);
        rst = 1'b0;

        // Reset register state and address decode
        read_check("stat_reset", UART_STAT, 32'h0000_0008);
        read_check("stat_alias", 4'h5, 32'h0000_0008);
        read_check("ctrl_reset", UART_CTRL, 0);
        wb_write(4'hC, 32'hFFFF_FFFF);
        read_check("reserved_rd", 4'hC, 0);
        read_check("ctrl_after_resv", UART_CTRL, 0);

        // Held strobe is acked exactly once; read data holds afterwards
        @(posedge clk); #1;
        wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = UART_STAT; wb_sel = 4'hF;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (wb_ack) acks++;
        end
        check("held_ack_once", acks, 1);
        check("held_dat", wb_dat_r, 32'h8);
        wb_cyc = 0; wb_stb = 0;
        @(posedge clk); #1;
        check("ack_drop", wb_ack, 0);
        check("dat_hold", wb_dat_r, 32'h8);

        // Exact TX waveform of 0x55
        wb_write(UART_DATA, 32'h0000_0055);
        tx_exp.push_back(8'h55);
        fr = {1'b1, 8'h55, 1'b0};
        mism = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(posedge clk); #1;
            if (uart_txd !== fr[i / CLK_DIV]) mism++;
        end
        check("tx_wave_55", mism, 0);
        read_check("tx_idle_after", UART_STAT, 32'h8);

        // DATA write with lane 0 disabled is not queued
        wb_xfer(1'b1, UART_DATA, 32'h0000_00AA, 4'b1110, r);
        repeat (5) @(posedge clk); #1;
        check("sel0_txd", uart_txd, 1);
        read_check("sel0_stat", UART_STAT, exp_status());

        // Burst: one frame on the wire, then 20 writes into a 16-deep FIFO
        w = $urandom;
        wb_write(UART_DATA, w);
        tx_exp.push_back(w[7:0]);
        m_tx_busy = 1'b1;
        slots = DEPTH;
        for (int i = 0; i < 20; i++) begin
            w = $urandom;
            wb_write(UART_DATA, w);
            if (slots > 0) begin
                tx_exp.push_back(w[7:0]);
                slots--;
            end
        end
        m_tx_full = (slots == 0);
        read_check("burst_stat", UART_STAT, exp_status());
        wait_tx_idle(20 * FRAME);
        m_tx_busy = 1'b0; m_tx_full = 1'b0;
        check("tx_count", tx_got.size(), tx_exp.size());
        n = (tx_got.size() < tx_exp.size()) ? tx_got.size() : tx_exp.size();
        for (int i = 0; i < n; i++) check($sformatf("tx_byte%0d", i), tx_got[i], tx_exp[i]);
        for (int i = 2; i < tx_start_cyc.size(); i++)
            check($sformatf("tx_gap%0d", i), tx_start_cyc[i] - tx_start_cyc[i-1], FRAME);

        // RX with interrupt enabled
        wb_write(UART_CTRL, 32'h1);
        check("irq_empty", irq, 0);
        rx_frame(8'hA3, 1'b1);
        check("irq_set", irq, 1);
        read_check("stat_avail", UART_STAT, exp_status());
        read_data_check("rx_a3");
        check("irq_pop_edge", irq, 1);
        @(posedge clk); #1;
        check("irq_pop_drop", irq, 0);
        for (int i = 0; i < 3; i++) begin
            b = $urandom;
            rx_frame(b, 1'b1);
        end
        for (int i = 0; i < 3; i++) read_data_check("rx_rand");

        // Overrun with interrupt disabled, then enable
        wb_write(UART_CTRL, 32'h0);
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = $urandom;
            rx_frame(b, 1'b1);
        end
        check("irq_masked", irq, 0);
        read_check("stat_overrun", UART_STAT, 32'h0000_000D);
        wb_write(UART_CTRL, 32'h1);
        check("irq_ctrl_lat0", irq, 0);
        @(posedge clk); #1;
        check("irq_ctrl_lat1", irq, 1);
        wb_write(UART_STAT, 32'h4);
        m_overrun = 1'b0;
        read_check("stat_w1c_ovr", UART_STAT, exp_status());
        for (int i = 0; i < DEPTH; i++) read_data_check($sformatf("rx_fifo%0d", i));
        read_check("rx_empty_rd", UART_DATA, 0);
        read_check("stat_drained", UART_STAT, 32'h8);
        check("irq_drained", irq, 0);

        // Short low glitch is rejected
        uart_rxd = 1'b0;
        repeat (CLK_DIV / 2 - 4) @(posedge clk); #1;
        uart_rxd = 1'b1;
        repeat (2 * FRAME) @(posedge clk); #1;
        read_check("glitch_stat", UART_STAT, exp_status());

        // Framing error, then a good frame after the line recovers
        b = $urandom;
        rx_frame(b, 1'b0);
        read_check("frame_err_stat", UART_STAT, exp_status());
        b = $urandom;
        rx_frame(b, 1'b1);
        read_check("rearm_stat", UART_STAT, exp_status());
        read_data_check("rearm_byte");
        wb_write(UART_STAT, 32'h10);
        m_frame = 1'b0;
        read_check("stat_w1c_fe", UART_STAT, exp_status());

        // Reset in the middle of a TX frame and with RX data pending
        b = $urandom;
        rx_frame(b, 1'b1);
        check("irq_before_rst", irq, 1);
        mon_en = 1'b0;
        wb_write(UART_DATA, 32'h0);
        repeat (3 * CLK_DIV) @(posedge clk); #1;
        check("txd_mid_frame", uart_txd, 0);
        #2 rst = 1'b1;
        #1 check("txd_async_rst", uart_txd, 1);
        check("irq_async_rst", irq, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_rx_q.delete();
        m_overrun = 0; m_frame = 0; m_tx_busy = 0; m_tx_full = 0;
        read_check("stat_post_rst", UART_STAT, 32'h8);
        read_check("ctrl_post_rst", UART_CTRL, 0);
        read_check("rx_post_rst", UART_DATA, 0);
        check("txd_post_rst", uart_txd, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
